// File: rtl/irq_pkg.sv
// Shared types, default sizes and the lowest-index search used by the
// interrupt aggregator.
package irq_pkg;

  localparam int NUM_SRC_DEF = 15;
  localparam int ID_W_DEF    = 4;
  // Search width of lowest_set_idx; bounds the number of sources at 32.
  localparam int ENC_W       = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_t;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [ENC_W-1:0] lowest_set_idx(input logic [ENC_W-1:0] vec);
    logic [ENC_W-1:0] idx;
    idx = {ENC_W{1'b0}};
    for (int i = ENC_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ENC_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the masked
// pending vector.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Any-set flag plus the winning index
  always_comb begin
    valid = |req;
    idx   = ID_W'(lowest_set_idx(ENC_W'(req)));
  end

endmodule

// File: rtl/irq_aggregator.sv
// Turns a vector of interrupt pulses into one held level interrupt plus a
// source ID, with pending latching, masking, overrun flags and an ack gap.
module irq_aggregator
  import irq_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk_100,
  input  logic               rst_100_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               irq_ack,
  input  logic [NUM_SRC-1:0] ovr_clr,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [NUM_SRC-1:0] irq_overrun
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [NUM_SRC-1:0] src_d_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] overrun_r;
  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] masked_s;

  irq_state_t         state_r;
  irq_state_t         state_nxt_s;
  logic               irq_out_r;
  logic               irq_out_nxt_s;
  logic [ID_W-1:0]    irq_id_r;
  logic [ID_W-1:0]    irq_id_nxt_s;
  logic [7:0]         gap_cnt_r;
  logic [7:0]         gap_cnt_nxt_s;

  logic               enc_valid_s;
  logic [ID_W-1:0]    enc_idx_s;

  // Rising-edge detect, ack-clear of the served source, and enable masking
  always_comb begin
    edge_s   = irq_src & ~src_d_r;
    masked_s = pending_r & irq_en;
    if ((state_r == ASSERT) && irq_ack) begin
      clr_s = NUM_SRC'(1'b1) << irq_id_r;
    end else begin
      clr_s = {NUM_SRC{1'b0}};
    end
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (masked_s),
    .valid (enc_valid_s),
    .idx   (enc_idx_s)
  );

  // Source history, pending latch (edge beats clear) and sticky overruns
  always_ff @(posedge clk_100 or negedge rst_100_n) begin
    if (!rst_100_n) begin
      src_d_r   <= {NUM_SRC{1'b0}};
      pending_r <= {NUM_SRC{1'b0}};
      overrun_r <= {NUM_SRC{1'b0}};
    end else begin
      src_d_r   <= irq_src;
      pending_r <= (pending_r & ~clr_s) | edge_s;
      overrun_r <= (overrun_r & ~ovr_clr) | (edge_s & pending_r & ~clr_s);
    end
  end

  // Service sequencer next-state: pick in IDLE, hold until ack, then quiet gap
  always_comb begin
    state_nxt_s   = state_r;
    irq_out_nxt_s = irq_out_r;
    irq_id_nxt_s  = irq_id_r;
    gap_cnt_nxt_s = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (enc_valid_s) begin
          state_nxt_s   = ASSERT;
          irq_out_nxt_s = 1'b1;
          irq_id_nxt_s  = enc_idx_s;
        end else begin
          irq_out_nxt_s = 1'b0;
        end
      end
      ASSERT: begin
        // Never withdrawn, even if the source is disabled meanwhile
        if (irq_ack) begin
          state_nxt_s   = GAP;
          irq_out_nxt_s = 1'b0;
          gap_cnt_nxt_s = 8'd0;
        end else begin
          irq_out_nxt_s = 1'b1;
        end
      end
      GAP: begin
        irq_out_nxt_s = 1'b0;
        if (gap_cnt_r >= GAP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        irq_out_nxt_s = 1'b0;
        gap_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Sequencer state and registered interrupt outputs
  always_ff @(posedge clk_100 or negedge rst_100_n) begin
    if (!rst_100_n) begin
      state_r   <= IDLE;
      irq_out_r <= 1'b0;
      irq_id_r  <= {ID_W{1'b0}};
      gap_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      irq_out_r <= irq_out_nxt_s;
      irq_id_r  <= irq_id_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

  assign irq_out     = irq_out_r;
  assign irq_id      = irq_id_r;
  assign irq_pending = pending_r;
  assign irq_overrun = overrun_r;

endmodule

// File: doc/irq_aggregator.md
Name: irq_aggregator

Overview:
- Consumes the 15-bit interrupt pulse vector from the timer interrupt stage and converts it into a single level interrupt plus a source ID for the MicroBlaze.
- Rising edges are latched as pending, gated by an enable mask and priority-encoded, with the lowest index winning.
- Each interrupt is held until the CPU acknowledges it.
- Overruns are flagged when a new edge arrives on a source that is still pending.

Parameters:
- NUM_SRC, 15: number of interrupt sources; matches the width of the timer interrupt pulse vector.
- ID_W, 4: width of the irq_id output; must satisfy 2**ID_W >= NUM_SRC.
- GAP_CYCLES, 2: minimum number of irq_out-low cycles after an ack before the next assertion; legal range 1..255.

Ports:
- clk_100  in  1  100 MHz system clock; all logic is on its rising edge.
- rst_100_n  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  interrupt pulse vector, synchronous to clk_100.
- irq_en  in  NUM_SRC  per-source enable mask, level, from the register file.
- irq_ack  in  1  one-cycle acknowledge pulse from the CPU.
- ovr_clr  in  NUM_SRC  write-one-to-clear strobe for the overrun flags.
- irq_out  out  1  level interrupt to the MicroBlaze.
- irq_id  out  ID_W  index of the source currently being signalled.
- irq_pending  out  NUM_SRC  raw pending register; not masked.
- irq_overrun  out  NUM_SRC  sticky overrun flags.

Behaviour:
- Reset: every register clears and every output reads 0; the FSM enters IDLE.
- Reset mid-operation drops irq_out in the same instant, because the reset is asynchronous.
- Edge detect: src_d holds irq_src registered by one cycle; edge = irq_src & ~src_d.
  - A source held high produces exactly one edge.
  - A source already high when reset releases produces an edge on the first cycle.
- Pending update, per bit i: pending[i] <= (pending[i] & ~clr[i]) | edge[i].
  - clr[i] is the ack-clear for the latched ID.
  - If an edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays set.
- Overrun: set overrun[i] when edge[i] & pending[i] & ~clr[i].
  - Clear it with ovr_clr[i].
  - If set and clear coincide, set wins.
- Masking: masked = pending & irq_en. Disabled sources still latch as pending and can still overrun.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: when masked is non-zero, latch irq_id = lowest set index of masked, set irq_out = 1 and move to ASSERT.
  - Latency: an irq_src rising edge at cycle N gives edge high at N, pending set at N+1, irq_out high at N+2.
  - ASSERT: irq_out and irq_id are held stable.
    - On irq_ack, clear pending[irq_id], drop irq_out in the next cycle and move to GAP.
    - If irq_en[irq_id] is removed while in ASSERT, the assertion is still held until ack; the interrupt is never withdrawn.
  - GAP: count GAP_CYCLES, then move to IDLE. irq_out is low throughout GAP.
  - irq_id keeps its last value outside ASSERT.
- irq_ack outside ASSERT is ignored; pending is not changed.
- Re-evaluation happens only in IDLE. A higher-priority source arriving during ASSERT does not preempt the current one; it is served next.
- Simultaneous edges on several sources set all of their pending bits; they are served in ascending index order, one ASSERT/GAP cycle each.
- Outputs are registered; there is no combinational path from any input to irq_out.

Decomposition:
- Shared package irq_pkg:
  - irq_state_t enum (IDLE, ASSERT, GAP).
  - Constants NUM_SRC_DEF = 15, ID_W_DEF = 4.
  - Function lowest_set_idx(), which returns 0 when its input is zero. Callers gate it with "any set".
- One natural sub-module, irq_prio_enc: a purely combinational lowest-index priority encoder producing a valid flag and an index.
- The edge/pending/overrun logic and the FSM stay in the top module.

Test Plan:
1. Single source: irq_en=0x7FFF, 1-cycle pulse on irq_src[3] at cycle 10.
   - irq_out rises at cycle 12 with irq_id=3.
   - Ack at cycle 20: irq_out falls at 21, pending becomes 0x0000.
   - irq_out stays low for 2 cycles.
2. Priority: pulses on bits 9 and 2 in the same cycle.
   - irq_id=2 first; after ack + GAP, irq_id=9.
   - pending reads 0x0204, then 0x0200, then 0x0000.
3. Mask: irq_en=0x0000, pulse on bit 5.
   - pending=0x0020 and irq_out stays 0.
   - Raise irq_en[5]: irq_out rises 1 cycle later with irq_id=5.
4. Overrun: pulse bit 1 twice, 4 cycles apart, with no ack.
   - overrun=0x0002 and only one service occurs.
   - ovr_clr=0x0002 returns overrun to 0.
5. Edge/clear collision: a new pulse on bit 0 arrives in the same cycle as the ack of ID 0.
   - pending[0] stays 1 and a second assertion follows after GAP.
   - overrun stays 0.
6. Reset: assert rst_100_n low during ASSERT.
   - irq_out goes 0 immediately and all outputs read 0.
   - A level-high source at release gives one new interrupt; a spurious irq_ack in IDLE has no effect.
